// File: rtl/cell_draw_datapath_pkg.sv
// Shared constants for the cell drawing datapath.
//   - Screen geometry and cell size used for clamping and alignment.
//   - CELL_LOG2: number of offset bits per axis inside one cell.
//   - State encodings for the IDLE / PLOT / DONE machine.
package cell_draw_datapath_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int CELL_SIZE = 4;
  localparam int CELL_LOG2 = $clog2(CELL_SIZE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLOT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/cell_draw_datapath_counter.sv
// cell_offset_counter: walks every pixel offset inside one square cell.
// The count is split so the low field is the x offset (fastest) and the
// high field is the y offset, giving row-major order.
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   clear         - synchronous return to offset (0,0); wins over enable
//   enable        - advance one pixel
//   x_off, y_off  - current offset inside the cell
//   terminal      - high on the last pixel of the cell
module cell_offset_counter #(
  parameter int OFF_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [OFF_W-1:0] x_off,
  output logic [OFF_W-1:0] y_off,
  output logic             terminal
);

  localparam int CNT_W = 2 * OFF_W;

  logic [CNT_W-1:0] cnt_r;

  // Pixel offset counter; wraps to zero after the last pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign x_off    = cnt_r[OFF_W-1:0];
  assign y_off    = cnt_r[CNT_W-1:OFF_W];
  assign terminal = (cnt_r == {CNT_W{1'b1}});

endmodule

// File: rtl/cell_draw_datapath.sv
// cell_draw_datapath: latches a cell coordinate from the switches and,
// on a draw request, plots one CELL_SIZE x CELL_SIZE square into the VGA
// adapter at one pixel per cycle, then reports completion.
// Ports:
//   clock, reset     - clock and asynchronous active-high reset
//   ldX, ldY         - load x / y base from data_in (only when not plotting)
//   draw             - level request from the control FSM
//   data_in          - coordinate value
//   colour_in        - cell colour, captured when a burst starts
//   x_out, y_out     - pixel coordinate to the adapter (base when not plotting)
//   colour_out       - pixel colour
//   writeEn, busy    - high during every plotted pixel
//   done             - high after a burst until draw drops
module cell_draw_datapath #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ldX,
  input  logic                ldY,
  input  logic                draw,
  input  logic [7:0]          data_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

  import cell_draw_datapath_pkg::*;

  // Clamp limits and alignment masks; clearing the low CELL_LOG2 bits after
  // clamping keeps base + offset on screen, so the adders can never wrap.
  localparam logic [X_W-1:0] X_MAX  = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] X_MASK = ~X_W'(CELL_SIZE - 1);
  localparam logic [Y_W-1:0] Y_MASK = ~Y_W'(CELL_SIZE - 1);

  logic [1:0]           state_r;
  logic [1:0]           state_next_s;
  logic [X_W-1:0]       x_base_r;
  logic [Y_W-1:0]       y_base_r;
  logic [COLOUR_W-1:0]  colour_r;
  logic [X_W-1:0]       x_in_s;
  logic [Y_W-1:0]       y_in_s;
  logic [X_W-1:0]       x_load_s;
  logic [Y_W-1:0]       y_load_s;
  logic                 load_ok_s;
  logic                 start_s;
  logic                 plotting_s;
  logic [CELL_LOG2-1:0] x_off_s;
  logic [CELL_LOG2-1:0] y_off_s;
  logic                 last_pix_s;

  assign x_in_s     = data_in[X_W-1:0];
  assign y_in_s     = data_in[Y_W-1:0];
  assign x_load_s   = ((x_in_s > X_MAX) ? X_MAX : x_in_s) & X_MASK;
  assign y_load_s   = ((y_in_s > Y_MAX) ? Y_MAX : y_in_s) & Y_MASK;
  assign plotting_s = (state_r == PLOT);
  // The base is frozen for the whole burst.
  assign load_ok_s  = !plotting_s;
  assign start_s    = (state_r == IDLE) && draw;

  // Offset counter is held at zero outside PLOT so IDLE/DONE show the base.
  cell_offset_counter #(
    .OFF_W (CELL_LOG2)
  ) u_offset (
    .clock    (clock),
    .reset    (reset),
    .clear    (!plotting_s),
    .enable   (plotting_s),
    .x_off    (x_off_s),
    .y_off    (y_off_s),
    .terminal (last_pix_s)
  );

  // Coordinate base registers, loaded from the switches outside a burst.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_base_r <= {X_W{1'b0}};
      y_base_r <= {Y_W{1'b0}};
    end else begin
      if (ldX && load_ok_s) begin
        x_base_r <= x_load_s;
      end else begin
        x_base_r <= x_base_r;
      end
      if (ldY && load_ok_s) begin
        y_base_r <= y_load_s;
      end else begin
        y_base_r <= y_base_r;
      end
    end
  end

  // Cell colour, captured once as the burst starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      colour_r <= {COLOUR_W{1'b0}};
    end else if (start_s) begin
      colour_r <= colour_in;
    end else begin
      colour_r <= colour_r;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a started burst always runs to completion and DONE
  // waits for draw to drop so a held request cannot retrigger.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (draw) begin
          state_next_s = PLOT;
        end else begin
          state_next_s = IDLE;
        end
      end
      PLOT: begin
        if (last_pix_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = PLOT;
        end
      end
      DONE: begin
        if (draw) begin
          state_next_s = DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the registered state and offsets.
  always_comb begin
    writeEn    = plotting_s;
    busy       = plotting_s;
    done       = (state_r == DONE);
    x_out      = x_base_r + {{(X_W-CELL_LOG2){1'b0}}, x_off_s};
    y_out      = y_base_r + {{(Y_W-CELL_LOG2){1'b0}}, y_off_s};
    colour_out = colour_r;
  end

endmodule

// File: tb/tb_cell_draw_datapath.sv
module tb_cell_draw_datapath;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ldX = 1'b0;
  logic       ldY = 1'b0;
  logic       draw = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [2:0] colour_in = 3'd0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       writeEn;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int w0;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];

  cell_draw_datapath dut (
    .clock      (clock),
    .reset      (reset),
    .ldX        (ldX),
    .ldY        (ldY),
    .draw       (draw),
    .data_in    (data_in),
    .colour_in  (colour_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .writeEn    (writeEn),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int xb, input int yb, input int col);
    pix_t p;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        p.x = 8'(xb + c);
        p.y = 7'(yb + r);
        p.c = 3'(col);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  // Scoreboard: every pixel write must match the next expected pixel.
  always @(negedge clock) begin
    if (!reset && writeEn) begin
      pix_t e;
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 0, 1);
      end else begin
        e = exp_q.pop_front();
        checks++;
        assert ({x_out, y_out, colour_out} === {e.x, e.y, e.c}) else begin
          errors++;
          $error("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                 x_out, y_out, colour_out, e.x, e.y, e.c);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_writeEn", writeEn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_x", x_out, 8'd0);
    chk("rst_y", y_out, 7'd0);
    chk("rst_colour", colour_out, 3'd0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Basic burst: X=13 -> 12, Y=6 -> 4, colour 5, draw held 20 cycles
    ldX = 1'b1; data_in = 8'd13;
    tick();
    ldX = 1'b0; ldY = 1'b1; data_in = 8'd6;
    tick();
    ldY = 1'b0; colour_in = 3'b101;
    chk("idle_base_x", x_out, 8'd12);
    chk("idle_base_y", y_out, 7'd4);
    push_burst(12, 4, 5);
    w0 = writes_seen;
    draw = 1'b1;
    tick();
    chk("first_write_latency", writeEn, 1'b1);
    repeat (15) tick();
    chk("last_write_en", writeEn, 1'b1);
    chk("last_write_x", x_out, 8'd15);
    chk("last_write_y", y_out, 7'd7);
    tick();
    chk("done_after_last", done, 1'b1);
    chk("we_after_last", writeEn, 1'b0);
    repeat (3) tick();
    chk("no_retrigger_done", done, 1'b1);
    chk("no_retrigger_we", writeEn, 1'b0);
    chk("burst1_count", writes_seen - w0, 16);
    draw = 1'b0;
    tick();
    chk("idle_after_draw_low", done, 1'b0);

    // Clamp: X=200 -> 156, Y=127 -> 116; last write (159,119)
    ldX = 1'b1; data_in = 8'd200;
    tick();
    ldX = 1'b0; ldY = 1'b1; data_in = 8'd127;
    tick();
    ldY = 1'b0; colour_in = 3'b001;
    chk("clamp_x", x_out, 8'd156);
    chk("clamp_y", y_out, 7'd116);
    push_burst(156, 116, 1);
    w0 = writes_seen;
    draw = 1'b1;
    wait_done(40);
    chk("clamp_count", writes_seen - w0, 16);
    draw = 1'b0;
    tick();

    // Joint load to (8,8); ldX pulse during the burst must be ignored
    ldX = 1'b1; ldY = 1'b1; data_in = 8'd8;
    tick();
    ldX = 1'b0; ldY = 1'b0; colour_in = 3'b111;
    chk("joint_x", x_out, 8'd8);
    chk("joint_y", y_out, 7'd8);
    push_burst(8, 8, 7);
    draw = 1'b1;
    tick();
    repeat (3) tick();
    ldX = 1'b1; data_in = 8'd40;
    tick();
    ldX = 1'b0;
    wait_done(40);
    draw = 1'b0;
    tick();
    chk("x_frozen", x_out, 8'd8);
    ldX = 1'b1; data_in = 8'd40;
    tick();
    ldX = 1'b0;
    chk("x_reload", x_out, 8'd40);

    // Draw dropped after 2 writes: burst completes, DONE lasts one cycle
    colour_in = 3'b010;
    push_burst(40, 8, 2);
    w0 = writes_seen;
    draw = 1'b1;
    tick();
    tick();
    draw = 1'b0;
    wait_done(40);
    chk("drop_count", writes_seen - w0, 16);
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);

    // Async reset at write 5, then a fresh burst from (0,0)
    colour_in = 3'b110;
    push_burst(40, 8, 6);
    w0 = writes_seen;
    draw = 1'b1;
    tick();
    repeat (5) tick();
    chk("pre_reset_we", writeEn, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_we", writeEn, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_x", x_out, 8'd0);
    chk("async_rst_y", y_out, 7'd0);
    chk("async_rst_colour", colour_out, 3'd0);
    chk("async_rst_state", dut.state_r, 2'd0);
    chk("rst_partial_count", writes_seen - w0, 5);
    exp_q.delete();
    draw = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();
    chk("post_rst_x", x_out, 8'd0);
    chk("post_rst_y", y_out, 7'd0);
    colour_in = 3'b011;
    push_burst(0, 0, 3);
    w0 = writes_seen;
    draw = 1'b1;
    wait_done(40);
    chk("post_rst_count", writes_seen - w0, 16);
    draw = 1'b0;
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_draw_datapath.md
Name: cell_draw_datapath

Overview:
- Datapath responder to the X/Y/draw control FSM. It consumes ldX, ldY and draw, latches a cell coordinate, and plots one CELL_SIZE x CELL_SIZE square into the VGA adapter.
- It emits one pixel write per cycle, then reports completion.
- It sits between the control FSM and the VGA adapter's x/y/colour/writeEn inputs.

Parameters:
- X_W, 8, width of x coordinate (screen 160 wide)
- Y_W, 7, width of y coordinate (screen 120 high)
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- CELL_SIZE, 4, cell edge in pixels; must be a power of two and divide SCREEN_W and SCREEN_H
- COLOUR_W, 3, colour width

Ports:
- clock  in  1  system clock, all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- ldX  in  1  load x_base from data_in on this clock edge
- ldY  in  1  load y_base from data_in on this clock edge
- draw  in  1  level request from control; held high while control is in DRAW
- data_in  in  8  coordinate value (switches)
- colour_in  in  COLOUR_W  cell colour, sampled at burst start
- x_out  out  X_W  pixel x to VGA adapter
- y_out  out  Y_W  pixel y to VGA adapter
- colour_out  out  COLOUR_W  pixel colour
- writeEn  out  1  pixel write strobe, one pixel per high cycle
- busy  out  1  high while plotting
- done  out  1  high after a completed burst until draw drops

Behaviour:
- Reset (async, high): state=IDLE; x_base, y_base, cnt, colour_reg = 0; all outputs 0. Applies immediately, including mid-burst; writeEn drops in the same cycle reset asserts.
- Coordinate load:
  - ldX=1 at an edge: x_base <= align(min(data_in[X_W-1:0], SCREEN_W-1)).
  - ldY=1 at an edge: y_base <= align(min(data_in[Y_W-1:0], SCREEN_H-1)).
  - align() clears the low log2(CELL_SIZE) bits, so X=13 gives 12 and X=200 gives 156.
  - Loads are accepted only in IDLE and DONE. They are ignored in PLOT, so the base stays frozen during a burst.
  - ldX and ldY may be asserted together; both load.
- State machine (3 states, registered):
  - IDLE: if draw=1 at an edge, go to PLOT with cnt<=0 and colour_reg<=colour_in. Otherwise stay in IDLE.
  - PLOT: cnt increments each cycle. When cnt==CELL_SIZE^2-1, go to DONE. draw falling mid-burst does NOT abort; the burst always completes.
  - DONE: stay while draw=1; go to IDLE when draw=0. There is no retrigger while draw stays high.
- Outputs, combinational from registered state:
  - writeEn=busy=(state==PLOT).
  - done=(state==DONE).
  - x_out = x_base + cnt[log2(CELL)-1:0].
  - y_out = y_base + cnt[2*log2(CELL)-1:log2(CELL)].
  - colour_out = colour_reg.
  - In IDLE and DONE, x_out/y_out show the base coordinate.
- Timing:
  - draw sampled high at edge N gives the first write in cycle N+1.
  - Exactly CELL_SIZE^2 (16) consecutive writeEn cycles, in row-major order (x fastest).
  - done rises in the cycle after the last write.
- Width rules: additions are done in X_W/Y_W bits. Clamp plus align guarantees x_out ≤ SCREEN_W-1 and y_out ≤ SCREEN_H-1, so no wrap is possible.
- draw asserted while in DONE after a previous burst has no effect until draw has been seen low in IDLE.

Decomposition:
- Shared package holds:
  - state localparams (IDLE=2'd0, PLOT=2'd1, DONE=2'd2)
  - SCREEN_W, SCREEN_H, CELL_SIZE
  - CELL_LOG2
- One natural sub-module: cell_offset_counter, a log2(CELL_SIZE^2)-bit counter with clear, enable and terminal-count outputs, split into x/y offset fields.
- Clamp/align logic stays inline.

Test Plan:
- Reset asserted asynchronously between edges -> every output and the state go to 0 immediately; done=0, writeEn=0.
- Load X=13 (ldX), Y=6 (ldY), colour 3'b101, draw held for 20 cycles -> 16 writes (12,4),(13,4)..(15,4),(12,5)..(15,7), all with colour 5; first write one cycle after draw is sampled; done=1 from the next cycle and held with no second burst.
- Load X=200, Y=127, then draw -> base clamps to (156,116); the last write is (159,119); no coordinate exceeds the screen.
- During PLOT, pulse ldX with data_in=40 at write 3 -> the remaining writes keep the original x_base. After done and draw low, the next burst starts at x=40.
- Drop draw after 2 writes -> the burst still emits 16 writes, DONE is held for one cycle, then IDLE.
- Assert reset at write 5 -> writeEn falls immediately. After release, state is IDLE and bases are 0; a new draw plots (0,0)..(3,3).
